// File: rtl/riscv_core_mul_pkg.sv
// Shared types for the M-extension multiplier controller: op encodings, FSM
// states and the operand-signedness decode.
package riscv_core_mul_pkg;

    localparam int XLEN_DEF = 64;

    typedef enum logic [1:0] {
        MUL_OP_MUL    = 2'b00,
        MUL_OP_MULH   = 2'b01,
        MUL_OP_MULHSU = 2'b10,
        MUL_OP_MULHU  = 2'b11
    } mul_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_DONE = 2'b10
    } mul_state_e;

    // Returns {a_signed, b_signed} for a non-word op.
    function automatic logic [1:0] op_signedness(input mul_op_e op);
        logic [1:0] sgn;
        case (op)
            MUL_OP_MUL:    sgn = 2'b11;
            MUL_OP_MULH:   sgn = 2'b11;
            MUL_OP_MULHSU: sgn = 2'b10;
            MUL_OP_MULHU:  sgn = 2'b00;
            default:       sgn = 2'b00;
        endcase
        return sgn;
    endfunction

endpackage

// File: rtl/riscv_core_mul_out.sv
// Result selection from the captured 2*XLEN product; drives zero when disabled.
module riscv_core_mul_out
    import riscv_core_mul_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [2*XLEN-1:0] product,
    input  mul_op_e           control,
    input  logic              isword,
    input  logic              en,
    output logic [XLEN-1:0]   result
);

    // Pick low half, high half or sign-extended low word.
    always_comb begin
        result = '0;
        if (!en) begin
            result = '0;
        end else if (isword) begin
            result = {{(XLEN-32){product[31]}}, product[31:0]};
        end else begin
            case (control)
                MUL_OP_MUL:    result = product[XLEN-1:0];
                MUL_OP_MULH:   result = product[2*XLEN-1:XLEN];
                MUL_OP_MULHSU: result = product[2*XLEN-1:XLEN];
                MUL_OP_MULHU:  result = product[2*XLEN-1:XLEN];
                default:       result = product[2*XLEN-1:XLEN];
            endcase
        end
    end

endmodule

// File: rtl/riscv_core_mul_ctrl.sv
// Sequencing controller for the radix-16 Booth multiplier: decodes M-extension
// requests, launches the array, and reuses the last product when operands match.
module riscv_core_mul_ctrl
    import riscv_core_mul_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int MUL_LAT = 4
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_mul_ctrl_valid,
    output logic                o_mul_ctrl_ready,
    input  logic [1:0]          i_mul_ctrl_control,
    input  logic                i_mul_ctrl_isword,
    input  logic [XLEN-1:0]     i_mul_ctrl_rs1,
    input  logic [XLEN-1:0]     i_mul_ctrl_rs2,
    input  logic                i_mul_ctrl_flush,
    output logic                o_mul_ctrl_start,
    output logic [XLEN-1:0]     o_mul_ctrl_op_a,
    output logic [XLEN-1:0]     o_mul_ctrl_op_b,
    output logic                o_mul_ctrl_a_signed,
    output logic                o_mul_ctrl_b_signed,
    input  logic [2*XLEN-1:0]   i_mul_ctrl_product,
    output logic                o_mul_ctrl_result_valid,
    input  logic                i_mul_ctrl_result_ready,
    output logic [XLEN-1:0]     o_mul_ctrl_result,
    output logic                o_mul_ctrl_busy
);

    localparam int CNT_W = $clog2(MUL_LAT + 1);

    mul_state_e          state_r, state_nxt_s;
    logic [XLEN-1:0]     op_a_r, op_b_r, op_a_nxt_s, op_b_nxt_s;
    logic                a_signed_r, b_signed_r, a_signed_nxt_s, b_signed_nxt_s;
    mul_op_e             control_r;
    logic                isword_r;
    logic [2*XLEN-1:0]   product_r;
    logic [XLEN-1:0]     tag_a_r, tag_b_r;
    logic                tag_a_signed_r, tag_b_signed_r, tag_valid_r;
    logic [CNT_W-1:0]    cnt_r;
    logic                start_r;
    logic                ready_s, accept_s, reuse_hit_s, launch_s, capture_s;

    // Operand/signedness decode of the incoming request.
    always_comb begin
        op_a_nxt_s     = i_mul_ctrl_rs1;
        op_b_nxt_s     = i_mul_ctrl_rs2;
        a_signed_nxt_s = 1'b0;
        b_signed_nxt_s = 1'b0;
        if (i_mul_ctrl_isword) begin
            op_a_nxt_s     = {{(XLEN-32){i_mul_ctrl_rs1[31]}}, i_mul_ctrl_rs1[31:0]};
            op_b_nxt_s     = {{(XLEN-32){i_mul_ctrl_rs2[31]}}, i_mul_ctrl_rs2[31:0]};
            a_signed_nxt_s = 1'b1;
            b_signed_nxt_s = 1'b1;
        end else begin
            {a_signed_nxt_s, b_signed_nxt_s} = op_signedness(mul_op_e'(i_mul_ctrl_control));
        end
    end

    // Handshake, reuse detection and product capture qualifiers.
    always_comb begin
        ready_s = 1'b0;
        case (state_r)
            ST_IDLE: ready_s = ~i_mul_ctrl_flush;
            ST_DONE: ready_s = i_mul_ctrl_result_ready & ~i_mul_ctrl_flush;
            default: ready_s = 1'b0;
        endcase
        accept_s    = i_mul_ctrl_valid & ready_s;
        reuse_hit_s = tag_valid_r & ~i_mul_ctrl_isword &
                      (op_a_nxt_s == tag_a_r) & (op_b_nxt_s == tag_b_r) &
                      (a_signed_nxt_s == tag_a_signed_r) & (b_signed_nxt_s == tag_b_signed_r);
        launch_s    = accept_s & ~reuse_hit_s;
        capture_s   = (state_r == ST_CALC) & (cnt_r == {CNT_W{1'b0}}) & ~i_mul_ctrl_flush;
    end

    // Next-state logic; flush overrides everything.
    always_comb begin
        state_nxt_s = state_r;
        if (i_mul_ctrl_flush) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) state_nxt_s = reuse_hit_s ? ST_DONE : ST_CALC;
                    else          state_nxt_s = ST_IDLE;
                end
                ST_CALC: begin
                    if (capture_s) state_nxt_s = ST_DONE;
                    else           state_nxt_s = ST_CALC;
                end
                ST_DONE: begin
                    if (accept_s)                     state_nxt_s = reuse_hit_s ? ST_DONE : ST_CALC;
                    else if (i_mul_ctrl_result_ready) state_nxt_s = ST_IDLE;
                    else                              state_nxt_s = ST_DONE;
                end
                default: state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state_r <= ST_IDLE;
        else       state_r <= state_nxt_s;
    end

    // Request capture; operands stay frozen until the next accept.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            op_a_r     <= '0;
            op_b_r     <= '0;
            a_signed_r <= 1'b0;
            b_signed_r <= 1'b0;
            control_r  <= MUL_OP_MUL;
            isword_r   <= 1'b0;
        end else if (accept_s) begin
            op_a_r     <= op_a_nxt_s;
            op_b_r     <= op_b_nxt_s;
            a_signed_r <= a_signed_nxt_s;
            b_signed_r <= b_signed_nxt_s;
            control_r  <= mul_op_e'(i_mul_ctrl_control);
            isword_r   <= i_mul_ctrl_isword;
        end
    end

    // Latency counter and one-cycle launch pulse.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_r   <= '0;
            start_r <= 1'b0;
        end else begin
            start_r <= launch_s;
            if (launch_s)                                        cnt_r <= CNT_W'(MUL_LAT);
            else if (i_mul_ctrl_flush)                           cnt_r <= '0;
            else if ((state_r == ST_CALC) && (cnt_r != '0))      cnt_r <= cnt_r - CNT_W'(1);
            else                                                 cnt_r <= cnt_r;
        end
    end

    // Product register and reuse tag; a flush mid-calculation invalidates the tag.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            product_r      <= '0;
            tag_a_r        <= '0;
            tag_b_r        <= '0;
            tag_a_signed_r <= 1'b0;
            tag_b_signed_r <= 1'b0;
            tag_valid_r    <= 1'b0;
        end else if (i_mul_ctrl_flush && (state_r == ST_CALC)) begin
            tag_valid_r    <= 1'b0;
        end else if (capture_s) begin
            product_r      <= i_mul_ctrl_product;
            tag_a_r        <= op_a_r;
            tag_b_r        <= op_b_r;
            tag_a_signed_r <= a_signed_r;
            tag_b_signed_r <= b_signed_r;
            tag_valid_r    <= 1'b1;
        end
    end

    riscv_core_mul_out #(.XLEN(XLEN)) u_mul_out (
        .product (product_r),
        .control (control_r),
        .isword  (isword_r),
        .en      (o_mul_ctrl_result_valid),
        .result  (o_mul_ctrl_result)
    );

    assign o_mul_ctrl_ready        = ready_s;
    assign o_mul_ctrl_start        = start_r;
    assign o_mul_ctrl_op_a         = op_a_r;
    assign o_mul_ctrl_op_b         = op_b_r;
    assign o_mul_ctrl_a_signed     = a_signed_r;
    assign o_mul_ctrl_b_signed     = b_signed_r;
    assign o_mul_ctrl_result_valid = (state_r == ST_DONE);
    assign o_mul_ctrl_busy         = (state_r != ST_IDLE);

endmodule

// File: tb/tb_riscv_core_mul_ctrl.sv
// Directed bench for riscv_core_mul_ctrl with a fixed-latency multiplier model
// that only shows the true product in the single cycle it must be sampled.
module tb_riscv_core_mul_ctrl;

    localparam int XLEN    = 64;
    localparam int MUL_LAT = 4;
    localparam logic [127:0] JUNK = 128'hA5A5_5A5A_DEAD_BEEF_0F0F_F0F0_1234_5678;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               valid = 1'b0;
    logic               ready;
    logic [1:0]         control = 2'b00;
    logic               isword = 1'b0;
    logic [XLEN-1:0]    rs1 = '0;
    logic [XLEN-1:0]    rs2 = '0;
    logic               flush = 1'b0;
    logic               start;
    logic [XLEN-1:0]    op_a, op_b;
    logic               a_signed, b_signed;
    logic [2*XLEN-1:0]  product = JUNK;
    logic               result_valid;
    logic               result_ready = 1'b0;
    logic [XLEN-1:0]    result;
    logic               busy;

    int                 nvec = 0;
    int                 nfail = 0;
    logic [127:0]       exp_prod = '0;
    int                 pcnt = 0;
    logic               armed = 1'b0;
    int                 vcyc, nstart, scyc, cnt;

    riscv_core_mul_ctrl #(.XLEN(XLEN), .MUL_LAT(MUL_LAT)) dut (
        .i_clk                   (clk),
        .i_rst                   (rst),
        .i_mul_ctrl_valid        (valid),
        .o_mul_ctrl_ready        (ready),
        .i_mul_ctrl_control      (control),
        .i_mul_ctrl_isword       (isword),
        .i_mul_ctrl_rs1          (rs1),
        .i_mul_ctrl_rs2          (rs2),
        .i_mul_ctrl_flush        (flush),
        .o_mul_ctrl_start        (start),
        .o_mul_ctrl_op_a         (op_a),
        .o_mul_ctrl_op_b         (op_b),
        .o_mul_ctrl_a_signed     (a_signed),
        .o_mul_ctrl_b_signed     (b_signed),
        .i_mul_ctrl_product      (product),
        .o_mul_ctrl_result_valid (result_valid),
        .i_mul_ctrl_result_ready (result_ready),
        .o_mul_ctrl_result       (result),
        .o_mul_ctrl_busy         (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] ref_prod(input logic [1:0] ctl, input logic w,
                                              input logic [63:0] a, input logic [63:0] b);
        logic [63:0]  wa, wb;
        logic [127:0] ea, eb;
        logic         sa, sb;
        wa = a; wb = b;
        if (w) begin
            wa = {{32{a[31]}}, a[31:0]};
            wb = {{32{b[31]}}, b[31:0]};
            sa = 1'b1; sb = 1'b1;
        end else begin
            sa = (ctl != 2'b11);
            sb = (ctl == 2'b00) || (ctl == 2'b01);
        end
        ea = {{64{sa & wa[63]}}, wa};
        eb = {{64{sb & wb[63]}}, wb};
        return ea * eb;
    endfunction

    // Multiplier model: product valid only in cycle start+MUL_LAT.
    always @(negedge clk) begin
        if (start) begin
            pcnt  = MUL_LAT;
            armed = 1'b1;
        end else if (armed && pcnt > 0) begin
            pcnt = pcnt - 1;
        end else begin
            armed = 1'b0;
        end
        product = (armed && pcnt == 0) ? exp_prod : JUNK;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        nvec++;
        assert (obs === expv) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Called at a negedge; leaves the bench at the negedge of cycle 1.
    task automatic issue(input logic [1:0] ctl, input logic w, input logic [63:0] a, input logic [63:0] b);
        valid = 1'b1; control = ctl; isword = w; rs1 = a; rs2 = b;
        exp_prod = ref_prod(ctl, w, a, b);
        #1 chk("accept_ready", {127'b0, ready}, 128'd1);
        @(posedge clk);
        @(negedge clk);
        valid = 1'b0;
        result_ready = 1'b0;
    endtask

    task automatic wait_result(output int vc, output int ns, output int sc);
        int c;
        c = 1; ns = 0; sc = -1;
        while (c < 40) begin
            if (start) begin
                ns++;
                if (sc < 0) sc = c;
            end
            if (result_valid) break;
            @(negedge clk);
            c++;
        end
        vc = c;
    endtask

    task automatic complete();
        result_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        result_ready = 1'b0;
        chk("post_hs_valid", {127'b0, result_valid}, 128'd0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_ready", {127'b0, ready}, 128'd1);
        chk("rst_start", {127'b0, start}, 128'd0);
        chk("rst_op_a", {64'b0, op_a}, 128'd0);
        chk("rst_op_b", {64'b0, op_b}, 128'd0);
        chk("rst_signed", {126'b0, a_signed, b_signed}, 128'd0);
        chk("rst_valid", {127'b0, result_valid}, 128'd0);
        chk("rst_result", {64'b0, result}, 128'd0);
        chk("rst_busy", {127'b0, busy}, 128'd0);
        @(negedge clk);

        // MUL 3 * -5
        issue(2'b00, 1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB);
        chk("mul_busy", {127'b0, busy}, 128'd1);
        chk("mul_signed", {126'b0, a_signed, b_signed}, 128'd3);
        wait_result(vcyc, nstart, scyc);
        chk("mul_start_cyc", 128'(scyc), 128'd1);
        chk("mul_nstart", 128'(nstart), 128'd1);
        chk("mul_valid_cyc", 128'(vcyc), 128'd6);
        chk("mul_result", {64'b0, result}, {64'b0, 64'hFFFF_FFFF_FFFF_FFF1});

        // Back-pressure: hold for three cycles.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_valid", {127'b0, result_valid}, 128'd1);
            chk("bp_result", {64'b0, result}, {64'b0, 64'hFFFF_FFFF_FFFF_FFF1});
            chk("bp_ready", {127'b0, ready}, 128'd0);
        end

        // Back-to-back accept from DONE: MULHSU -1 * 2
        result_ready = 1'b1;
        issue(2'b10, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2);
        chk("b2b_start", {127'b0, start}, 128'd1);
        chk("mulhsu_signed", {126'b0, a_signed, b_signed}, 128'd2);
        wait_result(vcyc, nstart, scyc);
        chk("mulhsu_valid_cyc", 128'(vcyc), 128'd6);
        chk("mulhsu_result", {64'b0, result}, {64'b0, 64'hFFFF_FFFF_FFFF_FFFF});
        complete();

        // MULHU same operands: signedness differs, so it must launch.
        issue(2'b11, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2);
        wait_result(vcyc, nstart, scyc);
        chk("mulhu_nstart", 128'(nstart), 128'd1);
        chk("mulhu_result", {64'b0, result}, 128'd1);
        complete();

        // MULHU -1 * -1 then MUL and MULH on the same operands.
        issue(2'b11, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
        wait_result(vcyc, nstart, scyc);
        chk("mulhu2_result", {64'b0, result}, {64'b0, 64'hFFFF_FFFF_FFFF_FFFE});
        complete();
        issue(2'b00, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
        wait_result(vcyc, nstart, scyc);
        chk("mul_lo_result", {64'b0, result}, 128'd1);
        complete();
        issue(2'b01, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
        wait_result(vcyc, nstart, scyc);
        chk("reuse_nstart", 128'(nstart), 128'd0);
        chk("reuse_valid_cyc", 128'(vcyc), 128'd1);
        chk("reuse_result", {64'b0, result}, 128'd0);
        complete();

        // MULW
        issue(2'b01, 1'b1, 64'h0000_0001_4000_0000, 64'd2);
        chk("mulw_op_a", {64'b0, op_a}, {64'b0, 64'h0000_0000_4000_0000});
        chk("mulw_op_b", {64'b0, op_b}, 128'd2);
        chk("mulw_signed", {126'b0, a_signed, b_signed}, 128'd3);
        wait_result(vcyc, nstart, scyc);
        chk("mulw_result", {64'b0, result}, {64'b0, 64'hFFFF_FFFF_8000_0000});
        complete();

        // Flush in CALC cycle 3 clears a tag that would otherwise hit.
        issue(2'b00, 1'b0, 64'd7, 64'd9);
        wait_result(vcyc, nstart, scyc);
        chk("mul79_result", {64'b0, result}, 128'd63);
        complete();
        issue(2'b11, 1'b0, 64'd7, 64'd9);
        @(negedge clk);
        @(negedge clk);
        flush = 1'b1;
        valid = 1'b1; control = 2'b00; isword = 1'b0; rs1 = 64'd7; rs2 = 64'd9;
        #1 chk("flush_ready", {127'b0, ready}, 128'd0);
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        valid = 1'b0;
        chk("flush_busy", {127'b0, busy}, 128'd0);
        chk("flush_start", {127'b0, start}, 128'd0);
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            if (result_valid) cnt++;
            @(negedge clk);
        end
        chk("flush_no_valid", 128'(cnt), 128'd0);
        issue(2'b00, 1'b0, 64'd7, 64'd9);
        wait_result(vcyc, nstart, scyc);
        chk("flush_relaunch", 128'(nstart), 128'd1);
        chk("flush_relaunch_cyc", 128'(vcyc), 128'd6);
        chk("flush_relaunch_res", {64'b0, result}, 128'd63);
        complete();

        // Asynchronous reset mid-CALC.
        issue(2'b00, 1'b0, 64'd5, 64'd5);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mrst_ready", {127'b0, ready}, 128'd1);
        chk("mrst_start", {127'b0, start}, 128'd0);
        chk("mrst_ops", {op_a, op_b}, 128'd0);
        chk("mrst_signed", {126'b0, a_signed, b_signed}, 128'd0);
        chk("mrst_valid", {127'b0, result_valid}, 128'd0);
        chk("mrst_result", {64'b0, result}, 128'd0);
        chk("mrst_busy", {127'b0, busy}, 128'd0);
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (result_valid || busy) cnt++;
            @(negedge clk);
        end
        chk("mrst_ignored", 128'(cnt), 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
